// File: rtl/heap_array_unit.sv
// heap_array_unit: shared heap-array manager for the program harness.
// Alloc/free with a LIFO free stack, element access and shifting edits.
module heap_array_unit #(
  parameter int WIDTH   = 12,
  parameter int NARRAYS = 4,
  parameter int NAREA   = 8,
  parameter int AW      = $clog2(NARRAYS),
  parameter int IW      = $clog2(NAREA + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AW-1:0]    cmd_array,
  input  logic [IW-1:0]    cmd_index,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_error,
  output logic [AW:0]      arrays_in_use
);

  localparam int D  = NARRAYS * NAREA;
  localparam int HW = $clog2(D);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  localparam logic [2:0] OP_ALLOC  = 3'd0;
  localparam logic [2:0] OP_FREE   = 3'd1;
  localparam logic [2:0] OP_READ   = 3'd2;
  localparam logic [2:0] OP_WRITE  = 3'd3;
  localparam logic [2:0] OP_SIZE   = 3'd4;
  localparam logic [2:0] OP_INSERT = 3'd5;
  localparam logic [2:0] OP_DELETE = 3'd6;
  localparam logic [2:0] OP_RESIZE = 3'd7;

  localparam logic [AW:0]   NA_MAX = (AW + 1)'(NARRAYS);
  localparam logic [IW-1:0] NE_MAX = IW'(NAREA);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] heap_q [D];
  logic [WIDTH-1:0] heap_d [D];
  logic [IW-1:0]    size_q [NARRAYS];
  logic [IW-1:0]    size_d [NARRAYS];
  logic [AW-1:0]    fstk_q [NARRAYS];
  logic [AW-1:0]    fstk_d [NARRAYS];
  logic [NARRAYS-1:0] used_q, used_d;
  logic [AW:0]      acnt_q, acnt_d;
  logic [AW:0]      fsp_q, fsp_d;
  logic [AW:0]      inuse_q, inuse_d;
  logic [2:0]       op_q, op_d;
  logic [AW-1:0]    arr_q, arr_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             err_q, err_d;
  logic             rv_q, rv_d;
  logic [WIDTH-1:0] rd_q, rd_d;
  logic             re_q, re_d;

  logic             accept;
  logic [IW-1:0]    sz;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    hnd;
  logic             can_alloc;

  function automatic logic [HW-1:0] haddr(
    input logic [AW-1:0] a,
    input logic [IW-1:0] i
  );
    return HW'(a) * HW'(NAREA) + HW'(i);
  endfunction

  assign cmd_ready     = (state_q == S_IDLE) && reset;
  assign accept        = cmd_valid && cmd_ready;
  assign rsp_valid     = rv_q;
  assign rsp_data      = rd_q;
  assign rsp_error     = re_q;
  assign arrays_in_use = inuse_q;

  // Command execution, shift sequencing and response staging
  always_comb begin
    state_d = state_q;
    heap_d  = heap_q;
    size_d  = size_q;
    fstk_d  = fstk_q;
    used_d  = used_q;
    acnt_d  = acnt_q;
    fsp_d   = fsp_q;
    inuse_d = inuse_q;
    op_d    = op_q;
    arr_d   = arr_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    dat_d   = dat_q;
    res_d   = res_q;
    err_d   = err_q;
    rv_d    = 1'b0;
    rd_d    = '0;
    re_d    = 1'b0;

    sz        = size_q[cmd_array];
    top_idx   = fsp_q[AW-1:0] - 1'b1;
    can_alloc = (fsp_q != '0) || (acnt_q < NA_MAX);
    hnd       = (fsp_q != '0) ? fstk_q[top_idx]
                              : acnt_q[AW-1:0];

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = cmd_op;
          arr_d   = cmd_array;
          idx_d   = cmd_index;
          dat_d   = cmd_data;
          res_d   = '0;
          err_d   = 1'b0;
          state_d = S_RESP;
          case (cmd_op)
            OP_ALLOC: begin
              if (!can_alloc) begin
                err_d = 1'b1;
              end else begin
                if (fsp_q != '0) fsp_d = fsp_q - 1'b1;
                else acnt_d = acnt_q + 1'b1;
                used_d[hnd] = 1'b1;
                size_d[hnd] = '0;
                inuse_d     = inuse_q + 1'b1;
                res_d       = WIDTH'(hnd);
              end
            end
            OP_FREE: begin
              if (!used_q[cmd_array]) begin
                err_d = 1'b1;
              end else begin
                fstk_d[fsp_q[AW-1:0]] = cmd_array;
                fsp_d  = fsp_q + 1'b1;
                used_d[cmd_array] = 1'b0;
                inuse_d = inuse_q - 1'b1;
              end
            end
            OP_READ: begin
              if (!used_q[cmd_array] || cmd_index >= sz)
                err_d = 1'b1;
              else
                res_d = heap_q[haddr(cmd_array, cmd_index)];
            end
            OP_WRITE: begin
              if (!used_q[cmd_array] || cmd_index >= NE_MAX) begin
                err_d = 1'b1;
              end else begin
                heap_d[haddr(cmd_array, cmd_index)] = cmd_data;
                if (cmd_index >= sz)
                  size_d[cmd_array] = cmd_index + 1'b1;
              end
            end
            OP_SIZE: begin
              if (!used_q[cmd_array]) err_d = 1'b1;
              else res_d = WIDTH'(sz);
            end
            OP_RESIZE: begin
              if (!used_q[cmd_array] || cmd_index > NE_MAX)
                err_d = 1'b1;
              else
                size_d[cmd_array] = cmd_index;
            end
            OP_INSERT: begin
              if (!used_q[cmd_array] || sz == NE_MAX ||
                  cmd_index > sz) begin
                err_d = 1'b1;
              end else if (cmd_index == sz) begin
                heap_d[haddr(cmd_array, cmd_index)] = cmd_data;
                size_d[cmd_array] = sz + 1'b1;
              end else begin
                ptr_d   = sz - 1'b1;
                state_d = S_SHIFT;
              end
            end
            default: begin
              if (!used_q[cmd_array] || cmd_index >= sz) begin
                err_d = 1'b1;
              end else begin
                res_d = heap_q[haddr(cmd_array, cmd_index)];
                if (cmd_index == sz - 1'b1) begin
                  size_d[cmd_array] = sz - 1'b1;
                end else begin
                  ptr_d   = cmd_index;
                  state_d = S_SHIFT;
                end
              end
            end
          endcase
        end
      end
      S_SHIFT: begin
        if (op_q == OP_INSERT) begin
          heap_d[haddr(arr_q, ptr_q + 1'b1)] =
            heap_q[haddr(arr_q, ptr_q)];
          if (ptr_q == idx_q) begin
            heap_d[haddr(arr_q, idx_q)] = dat_q;
            size_d[arr_q] = size_q[arr_q] + 1'b1;
            state_d = S_RESP;
          end else begin
            ptr_d = ptr_q - 1'b1;
          end
        end else begin
          heap_d[haddr(arr_q, ptr_q)] =
            heap_q[haddr(arr_q, ptr_q + 1'b1)];
          if (ptr_q + IW'(2) == size_q[arr_q]) begin
            size_d[arr_q] = size_q[arr_q] - 1'b1;
            state_d = S_RESP;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      S_RESP: begin
        rv_d    = 1'b1;
        rd_d    = err_q ? '0 : res_q;
        re_d    = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Heap storage keeps its contents across reset
  always_ff @(posedge clock) begin
    heap_q <= heap_d;
  end

  // Control, bookkeeping and response registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      size_q  <= '{default: '0};
      fstk_q  <= '{default: '0};
      used_q  <= '0;
      acnt_q  <= '0;
      fsp_q   <= '0;
      inuse_q <= '0;
      op_q    <= '0;
      arr_q   <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      dat_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      rv_q    <= 1'b0;
      rd_q    <= '0;
      re_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      fstk_q  <= fstk_d;
      used_q  <= used_d;
      acnt_q  <= acnt_d;
      fsp_q   <= fsp_d;
      inuse_q <= inuse_d;
      op_q    <= op_d;
      arr_q   <= arr_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      dat_q   <= dat_d;
      res_q   <= res_d;
      err_q   <= err_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
      re_q    <= re_d;
    end
  end

endmodule

// File: tb/tb_heap_array_unit.sv
// tb_heap_array_unit: scoreboard bench for heap_array_unit.
// Command-level model predicts data, error, latency and usage count.
module tb_heap_array_unit;

  localparam int W  = 12;
  localparam int NA = 4;
  localparam int NE = 8;
  localparam int AW = 2;
  localparam int IW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = '0;
  logic [AW-1:0] cmd_array = '0;
  logic [IW-1:0] cmd_index = '0;
  logic [W-1:0]  cmd_data = '0;
  logic          rsp_valid;
  logic [W-1:0]  rsp_data;
  logic          rsp_error;
  logic [AW:0]   arrays_in_use;

  heap_array_unit #(.WIDTH(W), .NARRAYS(NA), .NAREA(NE)) dut (
    .clock(clock),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_array(cmd_array),
    .cmd_index(cmd_index),
    .cmd_data(cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .rsp_error(rsp_error),
    .arrays_in_use(arrays_in_use)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] d;
    logic         e;
    int           lat;
  } exp_t;

  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mm [NA][NE];
  int  msz [NA];
  bit  mused [NA];
  int  mstk[$];
  int  macnt;
  int  minuse;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < NA; a++) begin
      msz[a]   = 0;
      mused[a] = 1'b0;
    end
    mstk.delete();
    macnt  = 0;
    minuse = 0;
  endtask

  task automatic model(input int op, input int a, input int i,
                       input logic [W-1:0] d, output exp_t x);
    int h;
    x.d = '0;
    x.e = 1'b0;
    x.lat = 2;
    case (op)
      0: begin
        h = -1;
        if (mstk.size() > 0) h = mstk.pop_back();
        else if (macnt < NA) begin h = macnt; macnt++; end
        else x.e = 1'b1;
        if (!x.e) begin
          mused[h] = 1'b1;
          msz[h] = 0;
          minuse++;
          x.d = W'(h);
        end
      end
      1: begin
        if (!mused[a]) x.e = 1'b1;
        else begin
          mstk.push_back(a);
          mused[a] = 1'b0;
          minuse--;
        end
      end
      2: begin
        if (!mused[a] || i >= msz[a]) x.e = 1'b1;
        else x.d = mm[a][i];
      end
      3: begin
        if (!mused[a] || i >= NE) x.e = 1'b1;
        else begin
          mm[a][i] = d;
          if (i + 1 > msz[a]) msz[a] = i + 1;
        end
      end
      4: begin
        if (!mused[a]) x.e = 1'b1;
        else x.d = W'(msz[a]);
      end
      5: begin
        if (!mused[a] || msz[a] == NE || i > msz[a]) x.e = 1'b1;
        else begin
          x.lat = 2 + msz[a] - i;
          for (int k = msz[a]; k > i; k--) mm[a][k] = mm[a][k-1];
          mm[a][i] = d;
          msz[a]++;
        end
      end
      6: begin
        if (!mused[a] || i >= msz[a]) x.e = 1'b1;
        else begin
          x.d = mm[a][i];
          x.lat = 2 + msz[a] - i - 1;
          for (int k = i; k < msz[a] - 1; k++) mm[a][k] = mm[a][k+1];
          msz[a]--;
        end
      end
      default: begin
        if (!mused[a] || i > NE) x.e = 1'b1;
        else msz[a] = i;
      end
    endcase
  endtask

  task automatic drive(input int op, input int a, input int i,
                       input logic [W-1:0] d);
    int n;
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op    = op[2:0];
    cmd_array = a[AW-1:0];
    cmd_index = i[IW-1:0];
    cmd_data  = d;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(n), 0);
    @(posedge clock);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic cmd(input int op, input int a, input int i,
                     input logic [W-1:0] d, input string tag);
    exp_t x;
    int lat;
    model(op, a, i, d, x);
    sbq.push_back(x);
    drive(op, a, i, d);
    lat = 1;
    @(negedge clock);
    while (!rsp_valid && lat < 40) begin
      lat++;
      @(negedge clock);
    end
    x = sbq.pop_front();
    chk({tag, "_vld"}, 32'(rsp_valid), 1);
    chk({tag, "_lat"}, 32'(lat), 32'(x.lat));
    chk({tag, "_data"}, 32'(rsp_data), 32'(x.d));
    chk({tag, "_err"}, 32'(rsp_error), 32'(x.e));
    chk({tag, "_use"}, 32'(arrays_in_use), 32'(minuse));
    @(negedge clock);
    chk({tag, "_pulse"}, 32'(rsp_valid), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clock);
    chk("rst_ready", 32'(cmd_ready), 0);
    chk("rst_vld", 32'(rsp_valid), 0);
    chk("rst_err", 32'(rsp_error), 0);
    chk("rst_data", 32'(rsp_data), 0);
    chk("rst_use", 32'(arrays_in_use), 0);
    reset = 1'b1;
    @(negedge clock);
    chk("idle_ready", 32'(cmd_ready), 1);

    cmd(0, 0, 0, 0, "alloc0");
    cmd(3, 0, 2, 3, "wr2");
    cmd(3, 0, 3, 0, "wr3");
    cmd(3, 0, 0, 0, "wr0");
    cmd(3, 0, 1, 0, "wr1");
    cmd(4, 0, 0, 0, "size4");
    cmd(2, 0, 3, 0, "rd3");
    for (int r = 0; r < 3; r++) begin
      cmd(2, 0, 0, 0, "rnd0_rd");
      cmd(3, 0, 0, mm[0][0] + 1'b1, "rnd0_wr");
    end
    cmd(2, 0, 0, 0, "rd0_is3");
    for (int r = 0; r < 5; r++) begin
      cmd(2, 0, 1, 0, "rnd1_rd");
      cmd(3, 0, 1, mm[0][1] + 1'b1, "rnd1_wr");
    end
    cmd(2, 0, 1, 0, "rd1_is5");

    cmd(0, 0, 0, 0, "alloc1");
    cmd(0, 0, 0, 0, "alloc2");
    cmd(0, 0, 0, 0, "alloc3");
    cmd(0, 0, 0, 0, "alloc_full");
    cmd(1, 2, 0, 0, "free2");
    cmd(1, 1, 0, 0, "free1");
    cmd(0, 0, 0, 0, "lifo1");
    cmd(0, 0, 0, 0, "lifo2");

    cmd(3, 1, 0, 10, "a1_w0");
    cmd(3, 1, 1, 20, "a1_w1");
    cmd(3, 1, 2, 30, "a1_w2");
    cmd(5, 1, 1, 15, "ins_mid");
    for (int k = 0; k < 4; k++) cmd(2, 1, k, 0, "ins_rd");
    cmd(4, 1, 0, 0, "ins_size");
    cmd(6, 1, 0, 0, "del_head");
    for (int k = 0; k < 3; k++) cmd(2, 1, k, 0, "del_rd");
    cmd(4, 1, 0, 0, "del_size");

    for (int k = 0; k < NE; k++) cmd(3, 2, k, W'(100 + k), "fill");
    cmd(5, 2, 3, 7, "ins_full");
    cmd(2, 2, 3, 0, "full_rd3");
    cmd(2, 2, 7, 0, "full_rd7");
    cmd(2, 2, 8, 0, "rd_oob");
    cmd(1, 3, 0, 0, "free3");
    cmd(1, 3, 0, 0, "free_unalloc");
    cmd(7, 2, 9, 0, "resize9");
    cmd(7, 2, 5, 0, "resize5");
    cmd(4, 2, 0, 0, "size5");
    cmd(5, 2, 5, 55, "ins_end");
    cmd(6, 2, 5, 0, "del_last");
    cmd(5, 2, 0, 99, "ins_head");
    cmd(6, 2, 5, 0, "del_mid");

    for (int r = 0; r < 30; r++) begin
      cmd($urandom_range(7, 2), $urandom_range(2, 0),
          $urandom_range(9, 0), W'($urandom), "rand");
    end

    cmd(7, 2, 8, 0, "resize8");
    drive(6, 2, 0, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("mid_rst_vld", 32'(rsp_valid), 0);
      chk("mid_rst_ready", 32'(cmd_ready), 0);
    end
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    chk("post_rst_vld", 32'(rsp_valid), 0);
    chk("post_rst_use", 32'(arrays_in_use), 0);
    cmd(0, 0, 0, 0, "post_alloc");
    cmd(4, 0, 0, 0, "post_size");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
